// File: rtl/tk1_spi_pkg.sv
// Shared types and constants for the tk1 SPI flash reader.
// Define TK1_SPI_FAST_READ_EN to select the FAST READ header (0x0B plus one dummy byte).
package tk1_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CS_ON     = 4'd1,
    ST_HDR_ISSUE = 4'd2,
    ST_HDR_WAIT  = 4'd3,
    ST_DAT_ISSUE = 4'd4,
    ST_DAT_WAIT  = 4'd5,
    ST_CS_OFF    = 4'd6,
    ST_CS_HOLD   = 4'd7
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] DUMMY_BYTE    = 8'h00;

  localparam logic [2:0] HDR_LAST_READ = 3'd3;
  localparam logic [2:0] HDR_LAST_FAST = 3'd4;

`ifdef TK1_SPI_FAST_READ_EN
  localparam logic [7:0] HDR_CMD  = CMD_FAST_READ;
  localparam logic [2:0] HDR_LAST = HDR_LAST_FAST;
`else
  localparam logic [7:0] HDR_CMD  = CMD_READ;
  localparam logic [2:0] HDR_LAST = HDR_LAST_READ;
`endif

  // Index 4 only exists in the fast-read header, where it is the dummy byte.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] addr);
    case (idx)
      3'd0:    return HDR_CMD;
      3'd1:    return addr[23:16];
      3'd2:    return addr[15:8];
      3'd3:    return addr[7:0];
      default: return DUMMY_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/tk1_spi_out_buf.sv
// One-entry valid/ready output register for received flash bytes.
// can_load reports that a store this cycle will not overwrite an unconsumed byte.
module tk1_spi_out_buf (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       dout_rdy,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       can_load
);

  assign can_load = !dout_vld || dout_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout     <= 8'h00;
      dout_vld <= 1'b0;
    end else if (load) begin
      dout     <= load_data;
      dout_vld <= 1'b1;
    end else if (dout_vld && dout_rdy) begin
      dout_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/tk1_spi_flash_reader.sv
// Read-command sequencer driving the tk1 byte-level SPI master one byte at a time.
// Build option TK1_SPI_FAST_READ_EN switches to FAST READ with a 5-byte header.
module tk1_spi_flash_reader
  import tk1_spi_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int CS_HIGH_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [7:0]       dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             spi_enable,
  output logic             spi_enable_vld,
  output logic             spi_start,
  output logic [7:0]       spi_tx_data,
  output logic             spi_tx_data_vld,
  input  logic [7:0]       spi_rx_data,
  input  logic             spi_ready
);

  localparam logic [7:0] HOLD_LAST = 8'(CS_HIGH_CYCLES - 1);

  state_t           state;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] remaining;
  logic [2:0]       hdr_idx;
  logic [7:0]       hold_cnt;
  logic             aborted;
  logic             abort_hit;
  logic             buf_can_load;
  logic             store;

  // A live abort counts as well as the sticky one, so abort beats a same-cycle final byte.
  assign abort_hit = abort || aborted;
  assign store     = (state == ST_DAT_WAIT) && spi_ready && !abort_hit && buf_can_load;

  tk1_spi_out_buf u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (store),
    .load_data (spi_rx_data),
    .dout_rdy  (dout_rdy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .can_load  (buf_can_load)
  );

  // Issue strobes are raised on entry to an ISSUE state so they are visible during it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      spi_enable      <= 1'b0;
      spi_enable_vld  <= 1'b1;
      spi_start       <= 1'b0;
      spi_tx_data     <= 8'h00;
      spi_tx_data_vld <= 1'b0;
      addr_q          <= 24'h000000;
      remaining       <= '0;
      hdr_idx         <= 3'd0;
      hold_cnt        <= 8'h00;
      aborted         <= 1'b0;
    end else begin
      done            <= 1'b0;
      spi_start       <= 1'b0;
      spi_tx_data_vld <= 1'b0;
      spi_enable_vld  <= 1'b0;

      if (abort && (state inside {ST_CS_ON, ST_HDR_ISSUE, ST_HDR_WAIT, ST_DAT_ISSUE, ST_DAT_WAIT}))
        aborted <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (req) begin
            if (req_len != '0) begin
              addr_q         <= req_addr;
              remaining      <= req_len;
              busy           <= 1'b1;
              aborted        <= 1'b0;
              spi_enable     <= 1'b1;
              spi_enable_vld <= 1'b1;
              state          <= ST_CS_ON;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_CS_ON: begin
          if (spi_ready) begin
            hdr_idx         <= 3'd0;
            spi_tx_data     <= hdr_byte(3'd0, addr_q);
            spi_start       <= 1'b1;
            spi_tx_data_vld <= 1'b1;
            state           <= ST_HDR_ISSUE;
          end
        end
        ST_HDR_ISSUE: state <= ST_HDR_WAIT;
        ST_HDR_WAIT: begin
          if (spi_ready) begin
            if (abort_hit) begin
              spi_enable     <= 1'b0;
              spi_enable_vld <= 1'b1;
              state          <= ST_CS_OFF;
            end else if (hdr_idx == HDR_LAST) begin
              spi_tx_data     <= DUMMY_BYTE;
              spi_start       <= 1'b1;
              spi_tx_data_vld <= 1'b1;
              state           <= ST_DAT_ISSUE;
            end else begin
              hdr_idx         <= hdr_idx + 3'd1;
              spi_tx_data     <= hdr_byte(hdr_idx + 3'd1, addr_q);
              spi_start       <= 1'b1;
              spi_tx_data_vld <= 1'b1;
              state           <= ST_HDR_ISSUE;
            end
          end
        end
        ST_DAT_ISSUE: state <= ST_DAT_WAIT;
        ST_DAT_WAIT: begin
          if (spi_ready && abort_hit) begin
            spi_enable     <= 1'b0;
            spi_enable_vld <= 1'b1;
            state          <= ST_CS_OFF;
          end else if (store) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining != LEN_W'(1)) begin
              spi_tx_data     <= DUMMY_BYTE;
              spi_start       <= 1'b1;
              spi_tx_data_vld <= 1'b1;
              state           <= ST_DAT_ISSUE;
            end else begin
              spi_enable     <= 1'b0;
              spi_enable_vld <= 1'b1;
              done           <= 1'b1;
              state          <= ST_CS_OFF;
            end
          end
        end
        ST_CS_OFF: begin
          hold_cnt <= 8'h00;
          state    <= ST_CS_HOLD;
        end
        ST_CS_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
